// File: rtl/skid_fifo_pkg.sv
// Shared constants and helpers for the skid_fifo elastic buffer.
package skid_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DEPTH_DEFAULT = 4;
  localparam int AW            = clog2(DEPTH_DEFAULT);
  localparam int PTR_W         = AW + 1;

endpackage

// File: rtl/skid_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module skid_fifo_mem
  import skid_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/skid_fifo.sv
// Valid/ready elastic buffer with registered ready_s, occupancy count, almost-full and flush.
// SKID_FIFO_BYPASS_EN adds same-cycle cut-through from data_s to data_m while empty.
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int AFULL_THRESH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    valid_s,
  output logic                    ready_s,
  input  logic [DATA_WIDTH-1:0]   data_s,
  output logic                    valid_m,
  input  logic                    ready_m,
  output logic [DATA_WIDTH-1:0]   data_m,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_full
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  logic [ADDR_W:0]     r_wr_ptr;
  logic [ADDR_W:0]     r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_ready_s;
  logic                r_afull;

  logic                w_accept;
  logic                w_store;
  logic                w_pop;
  logic                w_empty;
  logic [ADDR_W:0]     w_count_next;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty  = (r_count == '0);
  assign w_accept = valid_s & r_ready_s;
  assign w_pop    = ~w_empty & ready_m;

`ifdef SKID_FIFO_BYPASS_EN
  logic w_pass;
  // An accepted beat on an empty buffer is offered downstream at once; it is stored only if not taken.
  assign w_pass  = w_empty & w_accept;
  assign w_store = w_accept & ~(w_pass & ready_m);
  assign valid_m = ~w_empty | w_pass;
  assign data_m  = w_empty ? data_s : w_rdata;
`else
  assign w_store = w_accept;
  assign valid_m = ~w_empty;
  assign data_m  = w_rdata;
`endif

  assign w_count_next = flush ? '0
                      : r_count + (ADDR_W+1)'(w_store) - (ADDR_W+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready_s <= 1'b0;
      r_afull   <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_store) r_wr_ptr <= r_wr_ptr + ONE;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + ONE;
      end
      r_count   <= w_count_next;
      r_ready_s <= (w_count_next != FULL_CNT);
      r_afull   <= (w_count_next >= AFULL_CNT);
    end
  end

  skid_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_store & ~flush),
    .waddr (r_wr_ptr[ADDR_W-1:0]),
    .wdata (data_s),
    .raddr (r_rd_ptr[ADDR_W-1:0]),
    .rdata (w_rdata)
  );

  assign ready_s     = r_ready_s;
  assign count       = r_count;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_skid_fifo.sv
// Directed and randomised checks of skid_fifo (DEPTH=4, AFULL_THRESH=3), with or without bypass.
module tb_skid_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
`ifdef SKID_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          valid_s;
  logic          ready_s;
  logic [DW-1:0] data_s;
  logic          valid_m;
  logic          ready_m;
  logic [DW-1:0] data_m;
  logic [2:0]    count;
  logic          almost_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skid_fifo #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .valid_s     (valid_s),
    .ready_s     (ready_s),
    .data_s      (data_s),
    .valid_m     (valid_m),
    .ready_m     (ready_m),
    .data_m      (data_m),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid_s = 1'b0; ready_m = 1'b0; data_s = '0;
    tick(); tick();
    #1;
    checks++; if (ready_s !== 1'b0) begin errors++; $display("FAIL reset_ready_s: got %b want 0", ready_s); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid_m: got %b want 0", valid_m); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    rst = 1'b0;
    tick();
    #1;
    checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL reset_release_ready_s: got %b want 1", ready_s); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_release_count: got %0d want 0", count); end
  endtask

  task automatic test_fill();
    logic [7:0] fill_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int exp_cnt [5] = '{0, 1, 2, 3, 4};
    bit exp_rdy [5] = '{1, 1, 1, 1, 0};
    bit exp_af  [5] = '{0, 0, 0, 1, 1};
    ready_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_s = (i < 4);
      if (i < 4) data_s = fill_d[i];
      #1;
      checks++; if (int'(count) !== exp_cnt[i]) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); end
      checks++; if (ready_s !== exp_rdy[i]) begin errors++; $display("FAIL fill_ready_s[%0d]: got %b want %b", i, ready_s, exp_rdy[i]); end
      checks++; if (almost_full !== exp_af[i]) begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, exp_af[i]); end
      tick();
    end
    ready_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL fill_drain_valid[%0d]: got %b want 1", k, valid_m); end
      checks++; if (data_m !== fill_d[k]) begin errors++; $display("FAIL fill_drain_data[%0d]: got %h want %h", k, data_m, fill_d[k]); end
      tick();
    end
    #1;
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL fill_empty_valid: got %b want 0", valid_m); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty_count: got %0d want 0", count); end
    ready_m = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] exp_d;
    bit         exp_v;
    int         exp_c;
    valid_s = 1'b1; ready_m = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_s = 8'h80 + 8'(k);
      #1;
      exp_v = BYP || (k > 0);
      exp_d = BYP ? 8'h80 + 8'(k) : 8'h80 + 8'(k) - 8'h01;
      exp_c = (BYP || k == 0) ? 0 : 1;
      checks++; if (int'(count) !== exp_c) begin errors++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, count, exp_c); end
      checks++; if (valid_m !== exp_v) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", k, valid_m, exp_v); end
      if (exp_v) begin
        checks++; if (data_m !== exp_d) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, data_m, exp_d); end
      end
      tick();
    end
    valid_s = 1'b0;
    #1;
    exp_v = !BYP;
    checks++; if (valid_m !== exp_v) begin errors++; $display("FAIL stream_tail_valid: got %b want %b", valid_m, exp_v); end
    if (exp_v) begin
      checks++; if (data_m !== 8'h87) begin errors++; $display("FAIL stream_tail_data: got %h want 87", data_m); end
    end
    tick();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d want 0", count); end
    ready_m = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] exp_seq [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    ready_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_s = 1'b1; data_s = 8'hA0 + 8'(i);
      tick();
    end
    data_s = 8'hB0; ready_m = 1'b1;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (ready_s !== 1'b0) begin errors++; $display("FAIL full_ready_s: got %b want 0", ready_s); end
    checks++; if (data_m !== 8'hA0) begin errors++; $display("FAIL full_pop_data: got %h want a0", data_m); end
    tick();
    ready_m = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_after_pop_count: got %0d want 3", count); end
    checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b want 1", ready_s); end
    tick();
    valid_s = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refill_count: got %0d want 4", count); end
    checks++; if (ready_s !== 1'b0) begin errors++; $display("FAIL full_refill_ready: got %b want 0", ready_s); end
    ready_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (data_m !== exp_seq[k]) begin errors++; $display("FAIL full_drain_data[%0d]: got %h want %h", k, data_m, exp_seq[k]); end
      tick();
    end
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain_count: got %0d want 0", count); end
    ready_m = 1'b0;
  endtask

  task automatic test_flush();
    ready_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_s = 1'b1; data_s = 8'hC0 + 8'(i);
      tick();
    end
    data_s = 8'hEE; flush = 1'b1;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL flush_pre_afull: got %b want 1", almost_full); end
    tick();
    flush = 1'b0; valid_s = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL flush_valid_m: got %b want 0", valid_m); end
    checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL flush_ready_s: got %b want 1", ready_s); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL flush_afull: got %b want 0", almost_full); end
    ready_m = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL flush_ghost_valid[%0d]: got %b want 0", k, valid_m); end
    end
    ready_m = 1'b0; valid_s = 1'b1; data_s = 8'h5A;
    tick();
    valid_s = 1'b0;
    #1;
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL flush_next_valid: got %b want 1", valid_m); end
    checks++; if (data_m !== 8'h5A) begin errors++; $display("FAIL flush_next_data: got %h want 5a", data_m); end
    ready_m = 1'b1;
    tick();
    ready_m = 1'b0;
  endtask

  task automatic test_reset_mid();
    ready_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_s = 1'b1; data_s = 8'hD0 + 8'(i);
      tick();
    end
    valid_s = 1'b0; rst = 1'b1;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 2", count); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (ready_s !== 1'b0) begin errors++; $display("FAIL rstmid_ready_s: got %b want 0", ready_s); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL rstmid_valid_m: got %b want 0", valid_m); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
    tick();
    #1;
    checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %b want 1", ready_s); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL rstmid_release_valid: got %b want 0", valid_m); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic [7:0] prev_d = '0;
    bit         prev_stall = 1'b0;
    bit         exp_rdy;
    bit         exp_v;
    int         beats = 0;
    int         cyc = 0;
    while (beats < 10000 && cyc < 70000) begin
      valid_s = 1'($urandom_range(0, 1));
      ready_m = 1'($urandom_range(0, 1));
      data_s  = 8'($urandom_range(0, 255));
      #1;
      exp_rdy = (q.size() != DEPTH);
      exp_v   = (q.size() != 0) || (BYP && valid_s && exp_rdy);
      checks++; if (int'(count) !== q.size()) begin errors++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, count, q.size()); end
      checks++; if (ready_s !== exp_rdy) begin errors++; $display("FAIL rand_ready_s@%0d: got %b want %b", cyc, ready_s, exp_rdy); end
      checks++; if (almost_full !== (q.size() >= AFT)) begin errors++; $display("FAIL rand_afull@%0d: got %b want %b", cyc, almost_full, q.size() >= AFT); end
      checks++; if (valid_m !== exp_v) begin errors++; $display("FAIL rand_valid_m@%0d: got %b want %b", cyc, valid_m, exp_v); end
      if (prev_stall) begin
        checks++; if (data_m !== prev_d) begin errors++; $display("FAIL rand_stall_data@%0d: got %h want %h", cyc, data_m, prev_d); end
      end
      if (valid_s && ready_s) q.push_back(data_s);
      if (valid_m && ready_m) begin
        beats++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_underflow@%0d: got %h want none", cyc, data_m);
        end else begin
          exp_d = q.pop_front();
          if (data_m !== exp_d) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, data_m, exp_d); end
        end
      end
      prev_stall = valid_m && !ready_m;
      prev_d     = data_m;
      tick();
      cyc++;
    end
    checks++; if (beats < 10000) begin errors++; $display("FAIL rand_timeout: got %0d beats want 10000", beats); end
    valid_s = 1'b0; ready_m = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_full_simultaneous();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
